// File: rtl/div8_iter_core.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, start/busy/done handshake.
// Latency: done high in the cycle after E(WIDTH); start-to-next-accept is WIDTH+2 cycles.
// Backpressure: start is ignored while busy; optional DIV8_DIVZERO_EARLY_EN short-circuits divide-by-zero.
module div8_iter_core #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH:0]     r_rem;      // partial remainder, one guard bit so T never overflows
    logic [WIDTH-1:0]   r_q;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   r_d;        // latched divisor
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_remout;

    logic [WIDTH:0]     w_t;
    logic [WIDTH:0]     w_d_ext;
    logic [WIDTH:0]     w_s;
    logic               w_bo;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_accept;
    logic               w_last;

    // Shifted remainder: the guard bit of R drops off, the next dividend bit enters at the LSB.
    assign w_t      = (WIDTH+1)'({r_rem, r_q[WIDTH-1]});
    assign w_d_ext  = {1'b0, r_d};
    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Borrow-ripple full-subtractor row computing T - D with borrow-in 0.
    always_comb begin
        logic b;
        b   = 1'b0;
        w_s = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            w_s[i] = w_t[i] ^ w_d_ext[i] ^ b;
            b      = (~w_t[i] & w_d_ext[i]) | (~(w_t[i] ^ w_d_ext[i]) & b);
        end
        w_bo = b;
    end

    // A final borrow means D did not fit: restore T and shift in a 0 quotient bit.
    assign w_rem_nxt = w_bo ? w_t : w_s;
    assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_bo};

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
`ifdef DIV8_DIVZERO_EARLY_EN
                    if (i_divisor == '0) w_state_nxt = S_DONE;
                    else                 w_state_nxt = S_RUN;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, one restoring step per RUN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_q   <= i_dividend;
            r_d   <= i_divisor;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef DIV8_DIVZERO_EARLY_EN
    logic r_div_zero;

    // Results update only on DONE entry: after the last step, or immediately for a zero divisor.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_quot     <= '0;
            r_remout   <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept && (i_divisor == '0)) begin
            r_quot     <= '1;
            r_remout   <= i_dividend;
            r_div_zero <= 1'b1;
        end else if ((r_state == S_RUN) && w_last) begin
            r_quot     <= w_q_nxt;
            r_remout   <= w_rem_nxt[WIDTH-1:0];
            r_div_zero <= 1'b0;
        end
    end

    assign o_div_zero = r_div_zero;
`else
    // Results update only on DONE entry, taking the outcome of the last step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_quot   <= '0;
            r_remout <= '0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_quot   <= w_q_nxt;
            r_remout <= w_rem_nxt[WIDTH-1:0];
        end
    end

    assign o_div_zero = 1'b0;
`endif

    assign o_quotient  = r_quot;
    assign o_remainder = r_remout;

endmodule

// File: tb/tb_div8_iter_core.sv
module tb_div8_iter_core;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    logic [WIDTH-1:0] held_q;
    logic [WIDTH-1:0] held_r;
    logic             held_dz;

    div8_iter_core #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .o_busy      (busy),
        .o_done      (done),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit early_zero(input logic [WIDTH-1:0] b);
`ifdef DIV8_DIVZERO_EARLY_EN
        return (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge with the DUT idle. Optionally re-pulses start with other
    // operands at cycle poke_at (counted in negedges after the accept edge).
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int poke_at, input logic [WIDTH-1:0] pa,
                           input logic [WIDTH-1:0] pb, input bit chk_spacing);
        int n;
        bit seen;
        logic [WIDTH-1:0] eq, er;
        int exp_lat;
        eq = (b == 0) ? {WIDTH{1'b1}} : WIDTH'(a / b);
        er = (b == 0) ? a : WIDTH'(a % b);
        exp_lat = early_zero(b) ? 1 : WIDTH + 1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            start = (n == poke_at);
            if (n == poke_at) begin
                dividend = pa;
                divisor  = pb;
            end
            if (done) seen = 1'b1;
            else begin
                chk("busy_run", busy, 1);
                chk("hold_q", quotient, held_q);
                chk("hold_r", remainder, held_r);
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", n, exp_lat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_zero", div_zero, early_zero(b));
        chk("busy_done", busy, 1);
        if (chk_spacing)
            chk("done_spacing", cyc - last_done_cyc, early_zero(b) ? 2 : WIDTH + 2);
        last_done_cyc = cyc;
        held_q  = eq;
        held_r  = er;
        held_dz = early_zero(b);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("idle_hold_q", quotient, held_q);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        held_q   = '0;
        held_r   = '0;
        held_dz  = 1'b0;
        rst_n    = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal and edge operands.
        run_div(8'd100, 8'd7, 0, 0, 0, 0);
        run_div(8'd255, 8'd1, 0, 0, 0, 0);
        run_div(8'd5, 8'd9, 0, 0, 0, 0);
        run_div(8'd255, 8'd255, 0, 0, 0, 0);
        run_div(8'd37, 8'd0, 0, 0, 0, 0);

        // Start re-pulsed mid-run is ignored; outputs hold until the next done.
        run_div(8'd100, 8'd7, 4, 8'd50, 8'd5, 0);
        run_div(8'd50, 8'd5, 0, 0, 0, 0);

        // Reset in the middle of a run aborts immediately.
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        chk("midrst_dz", div_zero, 0);
        held_q = '0;
        held_r = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_div(8'd200, 8'd3, 0, 0, 0, 0);

        // Randomized back-to-back operations against the arithmetic model.
        for (int k = 0; k < 400; k++) begin
            ra = WIDTH'($urandom);
            rb = (k % 37 == 0) ? '0 : WIDTH'($urandom_range(0, 255));
            run_div(ra, rb, 0, 0, 0, k != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
